// File: rtl/hififo_pkg.sv
// Shared constants for the hififo request path: PIO word map and descriptor layout.
package hififo_pkg;

    localparam logic [5:0] PIO_HIGH      = 6'd2;
    localparam int         PIO_CTRL_BASE = 16;
    localparam int         PIO_DATA_BASE = 17;

    localparam int ADDR_W  = 61;
    localparam int COUNT_W = 19;
    localparam int DESC_W  = ADDR_W + COUNT_W;

    // Descriptor as stored in the queue RAM: length in the upper bits, address below.
    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic [ADDR_W-1:0]  addr;
    } desc_t;

    // Control word of channel ch (flush / overflow clear).
    function automatic logic [5:0] pio_ctrl_addr(input int ch);
        return 6'(PIO_CTRL_BASE + 2 * ch);
    endfunction

    // Data word of channel ch (descriptor push).
    function automatic logic [5:0] pio_data_addr(input int ch);
        return 6'(PIO_DATA_BASE + 2 * ch);
    endfunction

endpackage

// File: rtl/block_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
module block_ram #(
    parameter int DBITS = 80,
    parameter int ABITS = 9
) (
    input  logic             clock,
    input  logic             write_valid,
    input  logic [ABITS-1:0] write_address,
    input  logic [DBITS-1:0] write_data,
    input  logic             read_valid,
    input  logic [ABITS-1:0] read_address,
    output logic [DBITS-1:0] read_data
);

    logic [DBITS-1:0] ram [2**ABITS];

    // Write port and one-cycle-latency read port; contents are never cleared.
    always_ff @(posedge clock) begin
        if (write_valid)
            ram[write_address] <= write_data;
        if (read_valid)
            read_data <= ram[read_address];
    end

endmodule

// File: rtl/hififo_request_rr.sv
// Per-channel descriptor queues filled over PIO, drained by a round-robin arbiter
// into a three-stage read pipeline that delivers one descriptor per cycle.
module hififo_request_rr
    import hififo_pkg::*;
#(
    parameter int         NCH        = 8,
    parameter logic [7:0] ENABLE     = 8'b00010001,
    parameter int         DEPTH_LOG2 = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pio_wvalid,
    input  logic [63:0]        pio_wdata,
    input  logic [5:0]         pio_addr,
    output logic [NCH-1:0]     r_valid,
    output logic [ADDR_W-1:0]  r_addr,
    output logic [COUNT_W-1:0] r_count,
    input  logic [NCH-1:0]     r_ready,
    output logic [NCH-1:0]     ch_full,
    output logic [NCH-1:0]     ch_overflow
);

    localparam int             PW       = DEPTH_LOG2 + 1;
    localparam int             CW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int             ABITS    = $clog2(NCH) + DEPTH_LOG2;
    localparam logic [NCH-1:0] EN       = ENABLE[NCH-1:0];
    localparam logic [PW-1:0]  FULL_OCC = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [COUNT_W-1:0] high_q;
    logic [PW-1:0]      p_in  [NCH];
    logic [PW-1:0]      p_out [NCH];
    logic [PW-1:0]      occ   [NCH];
    logic [NCH-1:0]     full, push_hit, push_ok, flush, ovf_clr, req, grant;
    logic [CW-1:0]      rr_next, grant_ch, push_ch;
    logic               grant_any;
    logic [ABITS-1:0]   wr_addr, rd_addr;
    logic [DESC_W-1:0]  ram_q;
    logic [NCH-1:0]     vld_p0, vld_p1, vld_p2;
    desc_t              desc_p1, desc_p2;
    logic               unused_wdata;

    assign unused_wdata = pio_wdata[2];

    // Occupancy per channel; pointer wrap is absorbed by the modulo subtraction.
    always_comb begin
        for (int i = 0; i < NCH; i++)
            occ[i] = p_in[i] - p_out[i];
    end

    // PIO decode and arbitration requests; full is judged before any same-cycle pop.
    always_comb begin
        full     = '0;
        push_hit = '0;
        flush    = '0;
        ovf_clr  = '0;
        req      = '0;
        for (int i = 0; i < NCH; i++) begin
            full[i]     = EN[i] && (occ[i] == FULL_OCC);
            push_hit[i] = pio_wvalid && EN[i] && (pio_addr == pio_data_addr(i));
            flush[i]    = pio_wvalid && EN[i] && (pio_addr == pio_ctrl_addr(i)) && pio_wdata[0];
            ovf_clr[i]  = pio_wvalid && EN[i] && (pio_addr == pio_ctrl_addr(i)) && pio_wdata[1];
            req[i]      = EN[i] && r_ready[i] && (occ[i] != '0) && !flush[i];
        end
    end

    assign push_ok = push_hit & ~full;

    // Channel addressed by the current push (at most one per PIO write).
    always_comb begin
        push_ch = '0;
        for (int i = 0; i < NCH; i++)
            if (push_hit[i])
                push_ch = CW'(i);
    end

    // Round-robin search starting at the channel after the last grant.
    always_comb begin : arb
        logic [CW:0]   sum;
        logic [CW-1:0] idx;
        sum       = '0;
        idx       = '0;
        grant_any = 1'b0;
        grant_ch  = '0;
        for (int k = 0; k < NCH; k++) begin
            sum = {1'b0, rr_next} + (CW+1)'(k);
            if (sum >= (CW+1)'(NCH))
                sum = sum - (CW+1)'(NCH);
            idx = sum[CW-1:0];
            if (!grant_any && req[idx]) begin
                grant_any = 1'b1;
                grant_ch  = idx;
            end
        end
        grant = grant_any ? (NCH'(1) << grant_ch) : '0;
    end

    assign wr_addr = ABITS'({push_ch, p_in[push_ch][DEPTH_LOG2-1:0]});
    assign rd_addr = ABITS'({grant_ch, p_out[grant_ch][DEPTH_LOG2-1:0]});

    block_ram #(
        .DBITS (DESC_W),
        .ABITS (ABITS)
    ) u_ram (
        .clock         (clock),
        .write_valid   (|push_ok),
        .write_address (wr_addr),
        .write_data    ({high_q, pio_wdata[63:3]}),
        .read_valid    (grant_any),
        .read_address  (rd_addr),
        .read_data     (ram_q)
    );

    // High-word register and queue pointers; flush returns both pointers to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            high_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                p_in[i]  <= '0;
                p_out[i] <= '0;
            end
        end else begin
            if (pio_wvalid && (pio_addr == PIO_HIGH))
                high_q <= pio_wdata[21:3];
            for (int i = 0; i < NCH; i++) begin
                if (flush[i]) begin
                    p_in[i]  <= '0;
                    p_out[i] <= '0;
                end else begin
                    if (push_ok[i])
                        p_in[i] <= p_in[i] + PW'(1);
                    if (grant[i])
                        p_out[i] <= p_out[i] + PW'(1);
                end
            end
        end
    end

    // Sticky overflow: set by a push dropped on a full queue, cleared by control write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ch_overflow <= '0;
        else
            ch_overflow <= (ch_overflow & ~ovf_clr) | (push_hit & full);
    end

    // Round-robin pointer: next search starts after the granted channel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rr_next <= '0;
        else if (grant_any)
            rr_next <= (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + CW'(1);
    end

    // Pipeline valids: p0 = RAM read, p1 = data capture, p2 = output; flush kills in-flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p0 <= '0;
            vld_p1 <= '0;
            vld_p2 <= '0;
        end else begin
            vld_p0 <= grant;
            vld_p1 <= vld_p0 & ~flush;
            vld_p2 <= vld_p1 & ~flush;
        end
    end

    // Descriptor data follows the valids without reset.
    always_ff @(posedge clock) begin
        desc_p1 <= ram_q;
        desc_p2 <= desc_p1;
    end

    assign r_valid = vld_p2;
    assign r_addr  = desc_p2.addr;
    assign r_count = desc_p2.count;
    assign ch_full = full;

endmodule

// File: tb/tb_hififo_request_rr.sv
// Scoreboard bench for hififo_request_rr: stimulus queues expected descriptors,
// a monitor pops and compares each delivered descriptor.
module tb_hififo_request_rr;

    localparam int NCH = 8;
    localparam int DL  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        pio_wvalid;
    logic [63:0] pio_wdata;
    logic [5:0]  pio_addr;
    logic [7:0]  r_valid, r_ready, ch_full, ch_overflow;
    logic [60:0] r_addr;
    logic [18:0] r_count;

    always #5 clock = ~clock;

    hififo_request_rr #(
        .NCH        (NCH),
        .ENABLE     (8'b00010001),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pio_wvalid  (pio_wvalid),
        .pio_wdata   (pio_wdata),
        .pio_addr    (pio_addr),
        .r_valid     (r_valid),
        .r_addr      (r_addr),
        .r_count     (r_count),
        .r_ready     (r_ready),
        .ch_full     (ch_full),
        .ch_overflow (ch_overflow)
    );

    typedef struct {
        int          ch;
        logic [60:0] addr;
        logic [18:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   passes    = 0;
    int   delivered = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req)
            passes++;
        else
            $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic expect_desc(input int ch, input logic [60:0] a, input logic [18:0] c);
        exp_t e;
        e.ch    = ch;
        e.addr  = a;
        e.count = c;
        exp_q.push_back(e);
    endtask

    task automatic pio_write(input logic [5:0] a, input logic [63:0] d);
        @(negedge clock);
        pio_wvalid = 1'b1;
        pio_addr   = a;
        pio_wdata  = d;
    endtask

    task automatic pio_idle();
        @(negedge clock);
        pio_wvalid = 1'b0;
    endtask

    task automatic set_high(input logic [18:0] c);
        pio_write(6'd2, {42'd0, c, 3'b000});
    endtask

    task automatic push(input int ch, input logic [60:0] a);
        pio_write(6'(17 + 2 * ch), {a, 3'b000});
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        r_ready    = '0;
        pio_wvalid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clock);
            n++;
        end
        #2;
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(negedge clock);
    endtask

    // Monitor: every delivered descriptor must match the head of the scoreboard.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (!reset && r_valid !== '0) begin
                exp_t       e;
                logic [7:0] want;
                delivered++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_desc: r_valid %0h r_addr %0h, required no delivery", r_valid, r_addr);
                end else begin
                    e    = exp_q.pop_front();
                    want = 8'(1 << e.ch);
                    check("r_valid", r_valid, want);
                    check("r_addr", r_addr, e.addr);
                    check("r_count", r_count, e.count);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passes, checks);
        $fatal(1);
    end

    initial begin
        int base;
        reset      = 1'b1;
        pio_wvalid = 1'b0;
        pio_wdata  = '0;
        pio_addr   = '0;
        r_ready    = '0;
        repeat (3) @(negedge clock);
        check("reset_r_valid", r_valid, 0);
        check("reset_ch_full", ch_full, 0);
        check("reset_ch_overflow", ch_overflow, 0);
        reset = 1'b0;

        // Single descriptor, three-cycle latency from grant.
        set_high(19'd5);
        push(0, 61'h200);
        expect_desc(0, 61'h200, 19'd5);
        pio_idle();
        r_ready = 8'h01;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("t1_latency2_idle", r_valid, 0);
        @(posedge clock);
        #1;
        check("t1_latency3_valid", r_valid, 8'h01);
        wait_drain("t1_drain", 20);

        // Alternation between channels 0 and 4; write to disabled channel 1 ignored.
        do_reset();
        set_high(19'd7);
        for (int k = 0; k < 3; k++) push(0, 61'h10 + 61'(k));
        for (int k = 0; k < 3; k++) push(4, 61'h40 + 61'(k));
        push(1, 61'h99);
        pio_idle();
        for (int k = 0; k < 3; k++) begin
            expect_desc(0, 61'h10 + 61'(k), 19'd7);
            expect_desc(4, 61'h40 + 61'(k), 19'd7);
        end
        r_ready = 8'hFF;
        wait_drain("t2_drain", 40);

        // Fill channel 4 past capacity.
        do_reset();
        set_high(19'd9);
        for (int k = 0; k < 17; k++) begin
            push(4, 61'h100 + 61'(k));
            pio_idle();
            if (k == 14) check("t3_not_full_15", ch_full, 0);
            if (k == 15) check("t3_full_16", ch_full, 8'h10);
            if (k == 15) check("t3_no_ovf_16", ch_overflow, 0);
            if (k == 16) check("t3_ovf_17", ch_overflow, 8'h10);
            if (k == 16) check("t3_still_full_17", ch_full, 8'h10);
        end
        for (int k = 0; k < 16; k++) expect_desc(4, 61'h100 + 61'(k), 19'd9);
        r_ready = 8'h10;
        wait_drain("t3_drain", 60);
        check("t3_empty_after_drain", ch_full, 0);
        check("t3_ovf_sticky", ch_overflow, 8'h10);
        pio_write(6'd24, 64'h2);
        pio_idle();
        check("t3_ovf_cleared", ch_overflow, 0);

        // Continuous push/pop on channel 0 across several pointer wraps.
        do_reset();
        set_high(19'd3);
        r_ready = 8'h01;
        for (int k = 0; k < 100; k++) begin
            push(0, 61'h5000 + 61'(k));
            expect_desc(0, 61'h5000 + 61'(k), 19'd3);
        end
        pio_idle();
        wait_drain("t4_drain", 200);
        check("t4_no_ovf", ch_overflow, 0);
        check("t4_not_full", ch_full, 0);

        // Flush one cycle after grant suppresses the in-flight descriptor.
        r_ready = 8'h00;
        push(0, 61'h777);
        pio_idle();
        base    = delivered;
        r_ready = 8'h01;
        pio_write(6'd16, 64'h1);
        r_ready = 8'h00;
        pio_idle();
        repeat (6) @(negedge clock);
        check("t5_suppressed", delivered - base, 0);
        check("t5_not_full", ch_full, 0);
        push(0, 61'h778);
        expect_desc(0, 61'h778, 19'd3);
        pio_idle();
        r_ready = 8'h01;
        wait_drain("t5_drain", 20);

        // Asynchronous reset while a descriptor is on the output.
        push(0, 61'h999);
        expect_desc(0, 61'h999, 19'd3);
        pio_idle();
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #3;
        check("t6_valid_before_reset", r_valid, 8'h01);
        reset = 1'b1;
        #1;
        check("t6_async_clear", r_valid, 0);
        @(negedge clock);
        reset   = 1'b0;
        r_ready = 8'h00;
        check("t6_scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
